i2c_fifo_pair: RTL and testbench
================================

# i2c_fifo_pair

Single-clock TX/RX data buffer pair for the I2C controller, sitting between the APB register interface and the I2C data path. It generalises the earlier dual-FIFO buffer with parametrised width, depth and almost-thresholds, first-word-fall-through read data, fill-level counts, per-FIFO flush, and sticky overflow/underflow error flags. Both FIFOs run on the APB clock. The I2C core consumes and produces data through enable strobes synchronised into that domain upstream.

## Interface
- DATASIZE, 8, data word width
- ADDRSIZE, 4, log2 of depth; DEPTH = 2^ADDRSIZE (min ADDRSIZE = 2)
- AE_THRESH, 2, almost-empty when count <= AE_THRESH
- AF_THRESH, 14, almost-full when count >= AF_THRESH; requires 0 < AE_THRESH < AF_THRESH < DEPTH

Ports:
- pclk_i  in  1  sole clock, rising edge
- rst_i  in  1  asynchronous reset, active-high
- command_i  in  8  control bits:
  - [7] enable
  - [6] clear errors
  - [5] TX flush
  - [4] RX flush
  - [3] TX write
  - [2] TX read qualifier
  - [1] RX write qualifier
  - [0] RX read
- data_from_apb_i  in  DATASIZE  TX write data
- data_from_sda_i  in  DATASIZE  RX write data
- r_tx_fifo_en_i  in  1  TX read strobe from data path
- w_rx_fifo_en_i  in  1  RX write strobe from data path
- data_to_sda_o  out  DATASIZE  TX head word
- data_to_apb_o  out  DATASIZE  RX head word
- status_o  out  8  flags:
  - [7] TX empty, [6] TX full, [5] TX almost-empty, [4] TX almost-full
  - [3] RX empty, [2] RX full, [1] RX almost-empty, [0] RX almost-full
- tx_count_o  out  ADDRSIZE+1  TX occupancy, 0..DEPTH
- rx_count_o  out  ADDRSIZE+1  RX occupancy, 0..DEPTH
- err_o  out  4  sticky flags: [3] TX overflow, [2] TX underflow, [1] RX overflow, [0] RX underflow

## Operation
- Request strobes:
  - TX write = command_i[3]; TX read = r_tx_fifo_en_i & command_i[2].
  - RX write = w_rx_fifo_en_i & command_i[1]; RX read = command_i[0].
- Requests are all level-sampled per cycle. One word moves per cycle per held strobe.
- Per FIFO:
  - A read is accepted iff count != 0.
  - A write is accepted iff count != DEPTH, or a read is accepted in the same cycle. When full with read and write together, both complete and count is unchanged.
  - When empty with read and write together, the write is accepted and the read is rejected. There is no bypass.
- Pointers are ADDRSIZE bits wide and wrap modulo DEPTH. Count is ADDRSIZE+1 bits: +1 on write only, -1 on read only, unchanged otherwise.
- Head word output is mem[rd_ptr] when count != 0. It is all zeros when empty. This is FWFT: the word is valid before the read strobe.
- Flags:
  - empty = (count == 0); full = (count == DEPTH).
  - almost-empty = (count <= AE_THRESH); almost-full = (count >= AF_THRESH).
- Errors:
  - A rejected write sets the FIFO's overflow bit; a rejected read sets its underflow bit. The bits hold until command_i[6].
  - If a new error occurs in the same cycle as a clear, the set wins.
- Flush:
  - command_i[5] flushes TX; command_i[4] flushes RX; command_i[7] = 0 flushes both. Every cycle it is asserted, the flush zeroes that FIFO's pointers and count.
  - Flush has priority over same-cycle reads and writes. Those are ignored and raise no error.
  - Memory contents and err_o are not cleared by flush.
- Reset (rst_i high, asynchronous):
  - Pointers and counts are 0, err_o = 0, data outputs = 0.
  - status_o = 8'b1010_1010.
  - Memory contents are not reset.

## Timing
- All state updates on the rising pclk_i edge. Outputs are functions of registered state only. There is no combinational path from any input to any output.
- Write-to-read latency is 1 cycle. A word written at edge N appears on the head output and in count/status after edge N. With count 0 before, empty deasserts in the same cycle.
- Read: the head advances to the next word after the accepting edge.
- status_o, counts and err_o reflect the post-edge state. They lag a request by exactly one cycle.
- Reset is asserted asynchronously and released synchronously by the system reset generator. The block needs no internal synchroniser.

## Structure
- Package i2c_fifo_pkg holds:
  - command_i bit indices (CMD_EN, CMD_CLR_ERR, CMD_TX_FLUSH, CMD_RX_FLUSH, CMD_TX_WR, CMD_TX_RD, CMD_RX_WR, CMD_RX_RD)
  - status_o bit indices
  - err_o bit indices
- Sub-module i2c_sync_fifo_ch contains one single-clock FIFO channel: memory, pointers, count, four flags, overflow/underflow pulses.
  - The top instantiates it twice, once for TX and once for RX.
  - The top owns request qualification, flush muxing, sticky error registers and status packing.

## Test plan
- Reset -> status_o = 8'hAA, counts 0, err_o 0, data outputs 0.
- Write 0x01..0x10 into TX (16 writes) -> tx_count 16.
  - status[6] = 1 and status[4] = 1.
  - A 17th write sets err_o[3] and the head stays 0x01.
  - Sixteen reads return 0x01..0x10 in order.
- TX full, then simultaneous read and write 0xAA -> count stays 16, no error. After draining, 0xAA is the last word out.
- RX empty, then a read -> err_o[0] = 1.
  - Simultaneous RX write 0x5C and read -> count 1, head 0x5C.
  - command_i[6] clears err_o[0].
- RX at count 3 -> almost-empty (count 3 > 2) = 0. Reads down to count 2 -> almost-empty 1 in the next cycle. Writes up to count 14 -> almost-full 1.
- TX at count 5 -> command_i[5] with a concurrent write -> count 0, status[7] = 1, no error, RX unaffected.
  - command_i[7] = 0 -> both FIFOs empty.

Source files
------------

// File: rtl/i2c_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_fifo_pkg
//  Description : Shared bit indices for the I2C TX/RX FIFO pair: command
//                word decode, status flag packing and sticky error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_fifo_pkg;

    // command_i bit positions
    localparam int CMD_EN       = 7;
    localparam int CMD_CLR_ERR  = 6;
    localparam int CMD_TX_FLUSH = 5;
    localparam int CMD_RX_FLUSH = 4;
    localparam int CMD_TX_WR    = 3;
    localparam int CMD_TX_RD    = 2;
    localparam int CMD_RX_WR    = 1;
    localparam int CMD_RX_RD    = 0;

    // status_o bit positions
    localparam int ST_TX_EMPTY  = 7;
    localparam int ST_TX_FULL   = 6;
    localparam int ST_TX_AEMPTY = 5;
    localparam int ST_TX_AFULL  = 4;
    localparam int ST_RX_EMPTY  = 3;
    localparam int ST_RX_FULL   = 2;
    localparam int ST_RX_AEMPTY = 1;
    localparam int ST_RX_AFULL  = 0;

    // err_o bit positions
    localparam int ERR_TX_OVF   = 3;
    localparam int ERR_TX_UDF   = 2;
    localparam int ERR_RX_OVF   = 1;
    localparam int ERR_RX_UDF   = 0;

endpackage
`default_nettype wire

// File: rtl/i2c_sync_fifo_ch.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_sync_fifo_ch
//  Description : One single-clock first-word-fall-through FIFO channel with
//                occupancy count, empty/full/almost flags and one-cycle
//                overflow/underflow pulses for rejected requests.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_sync_fifo_ch #(
    parameter int DATASIZE  = 8,
    parameter int ADDRSIZE  = 4,
    parameter int AE_THRESH = 2,
    parameter int AF_THRESH = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_flush,
    input  logic                i_wr,
    input  logic                i_rd,
    input  logic [DATASIZE-1:0] i_wdata,
    output logic [DATASIZE-1:0] o_rdata,
    output logic [ADDRSIZE:0]   o_count,
    output logic                o_empty,
    output logic                o_full,
    output logic                o_aempty,
    output logic                o_afull,
    output logic                o_ovf,
    output logic                o_udf
);

    localparam logic [ADDRSIZE:0] c_depth     = (ADDRSIZE+1)'(1 << ADDRSIZE);
    localparam logic [ADDRSIZE:0] c_ae_thresh = (ADDRSIZE+1)'(AE_THRESH);
    localparam logic [ADDRSIZE:0] c_af_thresh = (ADDRSIZE+1)'(AF_THRESH);

    logic [DATASIZE-1:0] r_mem [0:(1<<ADDRSIZE)-1];
    logic [ADDRSIZE-1:0] r_wr_ptr;
    logic [ADDRSIZE-1:0] r_rd_ptr;
    logic [ADDRSIZE:0]   r_count;
    logic                w_rd_ok;
    logic                w_wr_ok;

    // Accept decisions; a full FIFO still takes a write if a read frees a slot
    // in the same cycle, an empty FIFO never forwards a same-cycle write.
    always_comb begin
        w_rd_ok = i_rd & (r_count != '0);
        w_wr_ok = i_wr & ((r_count != c_depth) | w_rd_ok);
        o_ovf   = ~i_flush & i_wr & ~w_wr_ok;
        o_udf   = ~i_flush & i_rd & ~w_rd_ok;
    end

    // Storage array, deliberately left out of reset
    always_ff @(posedge clk) begin
        if (w_wr_ok && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy tracking; flush overrides any same-cycle request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head word and flags derive from registered state only
    always_comb begin
        o_rdata  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
        o_count  = r_count;
        o_empty  = (r_count == '0);
        o_full   = (r_count == c_depth);
        o_aempty = (r_count <= c_ae_thresh);
        o_afull  = (r_count >= c_af_thresh);
    end

endmodule
`default_nettype wire

// File: rtl/i2c_fifo_pair.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_fifo_pair
//  Description : TX/RX data buffer pair between the APB register block and
//                the I2C data path. Qualifies requests, applies flushes,
//                keeps sticky overflow/underflow flags and packs status.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_fifo_pair
    import i2c_fifo_pkg::*;
#(
    parameter int DATASIZE  = 8,
    parameter int ADDRSIZE  = 4,
    parameter int AE_THRESH = 2,
    parameter int AF_THRESH = 14
) (
    input  logic                pclk_i,
    input  logic                rst_i,
    input  logic [7:0]          command_i,
    input  logic [DATASIZE-1:0] data_from_apb_i,
    input  logic [DATASIZE-1:0] data_from_sda_i,
    input  logic                r_tx_fifo_en_i,
    input  logic                w_rx_fifo_en_i,
    output logic [DATASIZE-1:0] data_to_sda_o,
    output logic [DATASIZE-1:0] data_to_apb_o,
    output logic [7:0]          status_o,
    output logic [ADDRSIZE:0]   tx_count_o,
    output logic [ADDRSIZE:0]   rx_count_o,
    output logic [3:0]          err_o
);

    logic       w_tx_flush, w_rx_flush;
    logic       w_tx_wr, w_tx_rd, w_rx_wr, w_rx_rd;
    logic       w_tx_empty, w_tx_full, w_tx_aempty, w_tx_afull;
    logic       w_rx_empty, w_rx_full, w_rx_aempty, w_rx_afull;
    logic       w_tx_ovf, w_tx_udf, w_rx_ovf, w_rx_udf;
    logic [3:0] w_err_set;
    logic [3:0] r_err;

    // Request qualification; a disabled block holds both FIFOs flushed and
    // flushed requests are dropped so they can raise no error
    always_comb begin
        w_tx_flush = command_i[CMD_TX_FLUSH] | ~command_i[CMD_EN];
        w_rx_flush = command_i[CMD_RX_FLUSH] | ~command_i[CMD_EN];
        w_tx_wr    = command_i[CMD_TX_WR] & ~w_tx_flush;
        w_tx_rd    = r_tx_fifo_en_i & command_i[CMD_TX_RD] & ~w_tx_flush;
        w_rx_wr    = w_rx_fifo_en_i & command_i[CMD_RX_WR] & ~w_rx_flush;
        w_rx_rd    = command_i[CMD_RX_RD] & ~w_rx_flush;
    end

    i2c_sync_fifo_ch #(
        .DATASIZE  (DATASIZE),
        .ADDRSIZE  (ADDRSIZE),
        .AE_THRESH (AE_THRESH),
        .AF_THRESH (AF_THRESH)
    ) u_tx_fifo (
        .clk      (pclk_i),
        .rst      (rst_i),
        .i_flush  (w_tx_flush),
        .i_wr     (w_tx_wr),
        .i_rd     (w_tx_rd),
        .i_wdata  (data_from_apb_i),
        .o_rdata  (data_to_sda_o),
        .o_count  (tx_count_o),
        .o_empty  (w_tx_empty),
        .o_full   (w_tx_full),
        .o_aempty (w_tx_aempty),
        .o_afull  (w_tx_afull),
        .o_ovf    (w_tx_ovf),
        .o_udf    (w_tx_udf)
    );

    i2c_sync_fifo_ch #(
        .DATASIZE  (DATASIZE),
        .ADDRSIZE  (ADDRSIZE),
        .AE_THRESH (AE_THRESH),
        .AF_THRESH (AF_THRESH)
    ) u_rx_fifo (
        .clk      (pclk_i),
        .rst      (rst_i),
        .i_flush  (w_rx_flush),
        .i_wr     (w_rx_wr),
        .i_rd     (w_rx_rd),
        .i_wdata  (data_from_sda_i),
        .o_rdata  (data_to_apb_o),
        .o_count  (rx_count_o),
        .o_empty  (w_rx_empty),
        .o_full   (w_rx_full),
        .o_aempty (w_rx_aempty),
        .o_afull  (w_rx_afull),
        .o_ovf    (w_rx_ovf),
        .o_udf    (w_rx_udf)
    );

    // Collect this cycle's error events in err_o bit order
    always_comb begin
        w_err_set             = '0;
        w_err_set[ERR_TX_OVF] = w_tx_ovf;
        w_err_set[ERR_TX_UDF] = w_tx_udf;
        w_err_set[ERR_RX_OVF] = w_rx_ovf;
        w_err_set[ERR_RX_UDF] = w_rx_udf;
    end

    // Sticky error flags; a new event beats a same-cycle clear
    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= '0;
        end else begin
            r_err <= (command_i[CMD_CLR_ERR] ? 4'b0000 : r_err) | w_err_set;
        end
    end

    // Status packing from both channels' registered-state flags
    always_comb begin
        status_o               = '0;
        status_o[ST_TX_EMPTY]  = w_tx_empty;
        status_o[ST_TX_FULL]   = w_tx_full;
        status_o[ST_TX_AEMPTY] = w_tx_aempty;
        status_o[ST_TX_AFULL]  = w_tx_afull;
        status_o[ST_RX_EMPTY]  = w_rx_empty;
        status_o[ST_RX_FULL]   = w_rx_full;
        status_o[ST_RX_AEMPTY] = w_rx_aempty;
        status_o[ST_RX_AFULL]  = w_rx_afull;
        err_o                  = r_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_fifo_pair.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_fifo_pair
//  Description : Directed self-checking bench for i2c_fifo_pair with a
//                queue-based reference model of both FIFOs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_fifo_pair;

    localparam int DEPTH = 16;
    localparam int AE    = 2;
    localparam int AF    = 14;

    logic       clk;
    logic       rst;
    logic [7:0] command;
    logic [7:0] apb_data;
    logic [7:0] sda_data;
    logic       tx_en;
    logic       rx_en;
    logic [7:0] to_sda;
    logic [7:0] to_apb;
    logic [7:0] status;
    logic [4:0] tx_count;
    logic [4:0] rx_count;
    logic [3:0] err;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [3:0] m_err;

    i2c_fifo_pair dut (
        .pclk_i          (clk),
        .rst_i           (rst),
        .command_i       (command),
        .data_from_apb_i (apb_data),
        .data_from_sda_i (sda_data),
        .r_tx_fifo_en_i  (tx_en),
        .w_rx_fifo_en_i  (rx_en),
        .data_to_sda_o   (to_sda),
        .data_to_apb_o   (to_apb),
        .status_o        (status),
        .tx_count_o      (tx_count),
        .rx_count_o      (rx_count),
        .err_o           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] flags(input int n);
        return {n == 0, n == DEPTH, n <= AE, n >= AF};
    endfunction

    // Reference comparison of every output against the queue model
    task automatic compare_all();
        logic [7:0] exp_tx_head;
        logic [7:0] exp_rx_head;
        exp_tx_head = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
        exp_rx_head = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        chk("tx_count", 32'(tx_count), 32'(tx_q.size()));
        chk("rx_count", 32'(rx_count), 32'(rx_q.size()));
        chk("tx_head", 32'(to_sda), 32'(exp_tx_head));
        chk("rx_head", 32'(to_apb), 32'(exp_rx_head));
        chk("status", 32'(status), 32'({flags(tx_q.size()), flags(rx_q.size())}));
        chk("err", 32'(err), 32'(m_err));
    endtask

    // Apply one cycle of inputs, advance the model by the same rules, check
    task automatic step(input logic [7:0] cmd, input logic [7:0] apb, input logic [7:0] sda,
                        input logic ten, input logic ren);
        logic       txf, rxf, rd, wr, rd_ok, wr_ok;
        logic [3:0] ev;
        command  = cmd;
        apb_data = apb;
        sda_data = sda;
        tx_en    = ten;
        rx_en    = ren;
        ev  = 4'b0000;
        txf = cmd[5] | ~cmd[7];
        rxf = cmd[4] | ~cmd[7];
        if (txf) begin
            tx_q.delete();
        end else begin
            rd    = ten & cmd[2];
            wr    = cmd[3];
            rd_ok = rd && (tx_q.size() > 0);
            wr_ok = wr && ((tx_q.size() < DEPTH) || rd_ok);
            ev[3] = wr && !wr_ok;
            ev[2] = rd && !rd_ok;
            if (rd_ok) void'(tx_q.pop_front());
            if (wr_ok) tx_q.push_back(apb);
        end
        if (rxf) begin
            rx_q.delete();
        end else begin
            rd    = cmd[0];
            wr    = ren & cmd[1];
            rd_ok = rd && (rx_q.size() > 0);
            wr_ok = wr && ((rx_q.size() < DEPTH) || rd_ok);
            ev[1] = wr && !wr_ok;
            ev[0] = rd && !rd_ok;
            if (rd_ok) void'(rx_q.pop_front());
            if (wr_ok) rx_q.push_back(sda);
        end
        m_err = (cmd[6] ? 4'b0000 : m_err) | ev;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        rst      = 1'b1;
        command  = 8'h80;
        apb_data = 8'h00;
        sda_data = 8'h00;
        tx_en    = 1'b0;
        rx_en    = 1'b0;
        m_err    = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("reset_status", 32'(status), 32'h0000_00AA);
        chk("reset_txcnt", 32'(tx_count), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        rst = 1'b0;

        // Fill TX with 0x01..0x10
        for (int i = 1; i <= 16; i++) step(8'h88, 8'(i), 8'h00, 1'b0, 1'b0);
        chk("tx_full_count", 32'(tx_count), 32'd16);
        chk("tx_full_flag", 32'(status[6]), 32'd1);
        chk("tx_afull_flag", 32'(status[4]), 32'd1);

        // Overflowing write
        step(8'h88, 8'h77, 8'h00, 1'b0, 1'b0);
        chk("tx_ovf", 32'(err[3]), 32'd1);
        chk("tx_head_after_ovf", 32'(to_sda), 32'h01);

        // Drain in order; head visible before each read strobe
        for (int i = 1; i <= 16; i++) begin
            chk("tx_drain_head", 32'(to_sda), 32'(i));
            step(8'h84, 8'h00, 8'h00, 1'b1, 1'b0);
        end
        chk("tx_drained", 32'(status[7]), 32'd1);

        // Clear errors, refill, then read+write while full
        step(8'hC0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("err_cleared", 32'(err), 32'd0);
        for (int i = 0; i < 16; i++) step(8'h88, 8'(8'h20 + i), 8'h00, 1'b0, 1'b0);
        step(8'h8C, 8'hAA, 8'h00, 1'b1, 1'b0);
        chk("full_rw_count", 32'(tx_count), 32'd16);
        chk("full_rw_err", 32'(err), 32'd0);
        for (int i = 0; i < 15; i++) step(8'h84, 8'h00, 8'h00, 1'b1, 1'b0);
        chk("last_word", 32'(to_sda), 32'h0000_00AA);
        step(8'h84, 8'h00, 8'h00, 1'b1, 1'b0);

        // RX underflow, then write+read on empty
        step(8'h81, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("rx_udf", 32'(err[0]), 32'd1);
        step(8'h83, 8'h00, 8'h5C, 1'b0, 1'b1);
        chk("rx_wr_rd_count", 32'(rx_count), 32'd1);
        chk("rx_wr_rd_head", 32'(to_apb), 32'h5C);
        step(8'hC0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("rx_udf_clear", 32'(err[0]), 32'd0);

        // RX thresholds
        step(8'h82, 8'h00, 8'h61, 1'b0, 1'b1);
        step(8'h82, 8'h00, 8'h62, 1'b0, 1'b1);
        chk("rx_cnt3_aempty", 32'(status[1]), 32'd0);
        step(8'h81, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("rx_cnt2_aempty", 32'(status[1]), 32'd1);
        for (int i = 0; i < 12; i++) step(8'h82, 8'h00, 8'(8'h70 + i), 1'b0, 1'b1);
        chk("rx_cnt14_afull", 32'(status[0]), 32'd1);

        // TX flush with concurrent write
        for (int i = 0; i < 5; i++) step(8'h88, 8'(8'h40 + i), 8'h00, 1'b0, 1'b0);
        step(8'hA8, 8'h99, 8'h00, 1'b0, 1'b0);
        chk("flush_txcnt", 32'(tx_count), 32'd0);
        chk("flush_empty", 32'(status[7]), 32'd1);
        chk("flush_err", 32'(err), 32'd0);
        chk("flush_rx_kept", 32'(rx_count), 32'd14);

        // Mixed traffic on both FIFOs
        for (int i = 0; i < 40; i++) begin
            step({4'b1000, 4'(i * 7 + 3)}, 8'(i * 13), 8'(i * 29 + 1), 1'(i % 3 != 0), 1'(i % 2));
        end

        // Disable flushes both
        step(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        chk("disable_status", 32'(status), 32'h0000_00AA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
